// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - packs a DATA_WIDTH byte stream into LANES-wide words with a keep mask
// Optional macro BYTE_PACKER_PARITY_EN adds out_parity, per-lane even parity of the presented word.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module byte_packer #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int LANES      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_WIDTH-1:0]       in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic [LANES-1:0]            out_keep,
    output logic                        out_last,
    output logic                        out_valid,
`ifdef BYTE_PACKER_PARITY_EN
    output logic [LANES-1:0]            out_parity,
`endif
    input  logic                        out_ready
);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(LANES - 1);

    logic [0:0]                  state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LANES*DATA_WIDTH-1:0] data_q, data_d;
    logic [LANES-1:0]            keep_q, keep_d;
    logic                        last_q, last_d;
    logic                        in_fire;
    logic                        out_fire;

    // In EMIT the packer can only take a byte when the held word leaves this same cycle.
    assign in_ready  = !rst && ((state_q == ST_FILL) || out_ready);
    assign out_valid = (state_q == ST_EMIT);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        case (state_q)
            ST_FILL: begin
                if (in_fire) begin
                    for (int i = 0; i < LANES; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            data_d[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
                            keep_d[i]                          = 1'b1;
                        end
                    end
                    if ((cnt_q == LAST_LANE) || in_last) begin
                        state_d = ST_EMIT;
                        last_d  = in_last;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_fire) begin
                    // Unused lanes must read as zero, so every consumed word clears the buffer.
                    data_d  = '0;
                    keep_d  = '0;
                    last_d  = 1'b0;
                    state_d = ST_FILL;
                    if (in_fire) begin
                        data_d[DATA_WIDTH-1:0] = in_data;
                        keep_d[0]              = 1'b1;
                        if ((LANES == 1) || in_last) begin
                            state_d = ST_EMIT;
                            last_d  = in_last;
                        end else begin
                            cnt_d = CNT_W'(1);
                        end
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
        end
    end

`ifdef BYTE_PACKER_PARITY_EN
    logic [LANES-1:0] parity_q, parity_d;

    always_comb begin
        parity_d = '0;
        for (int i = 0; i < LANES; i++) begin
            parity_d[i] = keep_d[i] & (^data_d[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// tb/tb_byte_packer.sv - scoreboard bench for byte_packer (LANES=4, 8-bit lanes)
module tb_byte_packer;

    localparam int DW = 8;
    localparam int LN = 4;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
`ifdef BYTE_PACKER_PARITY_EN
    logic [3:0]  out_parity;
`endif

    byte_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
`ifdef BYTE_PACKER_PARITY_EN
        .out_parity(out_parity),
`endif
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    word_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;
    int    cycle    = 0;
    int    word_cycles[$];

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every consumed word is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            word_cycles.push_back(cycle);
            if (exp_q.size() == 0) begin
                check("unexpected_word", out_data, 32'hDEAD_BEEF);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_keep", {28'd0, out_keep}, {28'd0, e.keep});
                check("out_last", {31'd0, out_last}, {31'd0, e.last});
`ifdef BYTE_PACKER_PARITY_EN
                begin
                    logic [3:0] p;
                    for (int i = 0; i < 4; i++) p[i] = e.keep[i] & (^e.data[i*8 +: 8]);
                    check("out_parity", {28'd0, out_parity}, {28'd0, p});
                end
`endif
            end
        end
    end

    // Drives one byte and waits (bounded) until the packer accepts it.
    task automatic send(input logic [7:0] d, input logic l, input logic chk_ready);
        bit ok;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            ok = in_ready;
            if (chk_ready) check("in_ready_stream", {31'd0, in_ready}, 32'd1);
            @(posedge clk);
            #1;
            if (ok) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
        end
        check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.data = d;
        w.keep = k;
        w.last = l;
        exp_q.push_back(w);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_keep", {28'd0, out_keep}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Full word, then out_valid lasts one cycle
        push(32'hA4A3A2A1, 4'hF, 1'b0);
        send(8'hA1, 1'b0, 1'b0);
        send(8'hA2, 1'b0, 1'b0);
        send(8'hA3, 1'b0, 1'b0);
        send(8'hA4, 1'b0, 1'b0);
        @(negedge clk);
        check("full_valid", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        check("full_valid_drop", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;

        // Partial packet
        push(32'h00002211, 4'h3, 1'b1);
        send(8'h11, 1'b0, 1'b0);
        send(8'h22, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure with a pending byte held on the input
        out_ready = 1'b0;
        push(32'hC4C3C2C1, 4'hF, 1'b0);
        send(8'hC1, 1'b0, 1'b0);
        send(8'hC2, 1'b0, 1'b0);
        send(8'hC3, 1'b0, 1'b0);
        send(8'hC4, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hC5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_data", out_data, 32'hC4C3C2C1);
            check("bp_keep", {28'd0, out_keep}, 32'hF);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        push(32'h0000C6C5, 4'h3, 1'b1);
        @(negedge clk);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        send(8'hC6, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Streaming: two words back to back, four cycles apart
        word_cycles.delete();
        push(32'h03020100, 4'hF, 1'b0);
        push(32'h07060504, 4'hF, 1'b0);
        for (int b = 0; b < 8; b++) send(8'(b), 1'b0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        if (word_cycles.size() == 2)
            check("stream_spacing", 32'(word_cycles[1] - word_cycles[0]), 32'd4);
        else
            check("stream_word_count", 32'(word_cycles.size()), 32'd2);

        // Reset mid-word discards partial lanes
        send(8'hE0, 1'b0, 1'b0);
        send(8'hE1, 1'b0, 1'b0);
        send(8'hE2, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push(32'hB3B2B1B0, 4'hF, 1'b0);
        send(8'hB0, 1'b0, 1'b0);
        send(8'hB1, 1'b0, 1'b0);
        send(8'hB2, 1'b0, 1'b0);
        send(8'hB3, 1'b0, 1'b0);

`ifdef BYTE_PACKER_PARITY_EN
        push(32'h01030700, 4'hF, 1'b0);
        send(8'h00, 1'b0, 1'b0);
        send(8'h07, 1'b0, 1'b0);
        send(8'h03, 1'b0, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        push(32'h000000FE, 4'h1, 1'b1);
        send(8'hFE, 1'b1, 1'b0);
`endif

        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
